// File: rtl/mdu_pkg.sv
// mdu_pkg: shared ALU/MDU operation codes and MDU state encoding
package mdu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
    ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11
  } alu_op_e;
  typedef enum logic [3:0] {
    OP_NOP   = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV  = 4'd3,
    OP_DIVU  = 4'd4, OP_MFHI = 4'd5, OP_MFLO  = 4'd6, OP_MTHI = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} mdu_state_e;
  function automatic logic is_mul(input logic [3:0] op);
    return op == OP_MULT || op == OP_MULTU;
  endfunction
  function automatic logic is_div(input logic [3:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction
endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational product / quotient / remainder on latched operands
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_wr
);
  logic        w_sdiv;
  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_ua, w_ub, w_den, w_q, w_r;
  // Signed divide works on magnitudes and fixes signs afterwards; this also
  // yields 0x80000000 / -1 = 0x80000000 with remainder 0 without a special case.
  always_comb begin
    w_sdiv   = i_op == OP_DIV;
    w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    w_prod_u = {32'd0, i_a} * {32'd0, i_b};
    w_ua     = (w_sdiv && i_a[31]) ? -i_a : i_a;
    w_ub     = (w_sdiv && i_b[31]) ? -i_b : i_b;
    w_den    = (w_ub == 32'd0) ? 32'd1 : w_ub;
    w_q      = w_ua / w_den;
    w_r      = w_ua % w_den;
    o_lo     = (i_op == OP_MULT)  ? w_prod_s[31:0] :
               (i_op == OP_MULTU) ? w_prod_u[31:0] :
               (w_sdiv && (i_a[31] ^ i_b[31])) ? -w_q : w_q;
    o_hi     = (i_op == OP_MULT)  ? w_prod_s[63:32] :
               (i_op == OP_MULTU) ? w_prod_u[63:32] :
               (w_sdiv && i_a[31]) ? -w_r : w_r;
    o_wr     = is_mul(i_op) || (is_div(i_op) && i_b != 32'd0);
  end
endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with HI/LO registers
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Src_A,
  input  logic [31:0] Src_B,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] MDU_Result
);
  mdu_state_e  r_state, w_state_nxt;
  logic [15:0] r_cnt;
  logic [3:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo, w_hi, w_lo;
  logic        w_wr, w_accept, w_done, w_idle;

  mdu_calc u_calc (.i_op(r_op), .i_a(r_a), .i_b(r_b), .o_hi(w_hi), .o_lo(w_lo), .o_wr(w_wr));

  // State register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_state_nxt;

  // Next state: accept a mult/div in IDLE, leave RUN on the last counted cycle
  always_comb begin
    w_idle      = r_state == S_IDLE;
    w_accept    = w_idle && Start && (is_mul(MDUOp) || is_div(MDUOp));
    w_done      = r_state == S_RUN && r_cnt == 16'd1;
    w_state_nxt = w_accept ? S_RUN : w_done ? S_IDLE : r_state;
    Busy        = r_state == S_RUN;
    MDU_Result  = (MDUOp == OP_MFHI) ? r_hi : (MDUOp == OP_MFLO) ? r_lo : 32'd0;
  end

  // Operand latch, counter and HI/LO; moves to HI/LO only apply in IDLE
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= MDUOp;
        r_a   <= Src_A;
        r_b   <= Src_B;
        r_cnt <= is_mul(MDUOp) ? 16'(MULT_CYCLES) : 16'(DIV_CYCLES);
      end else if (!w_idle) r_cnt <= r_cnt - 16'd1;
      if (w_done && w_wr) begin
        r_hi <= w_hi;
        r_lo <= w_lo;
      end else if (w_idle && Start && MDUOp == OP_MTHI) r_hi <= Src_A;
      else if (w_idle && Start && MDUOp == OP_MTLO) r_lo <= Src_A;
    end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5: cycles Busy stays high for MULT/MULTU.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10: cycles Busy stays high for DIV/DIVU.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port Src_A, input, 32: operand A (rs), the same forwarded operand the ALU receives.
REQ-006 SHALL have port Src_B, input, 32: operand B (rt), the same forwarded operand the ALU receives.
REQ-007 SHALL have port MDUOp, input, 4: operation select.
REQ-008 SHALL have port Start, input, 1: qualifies MDUOp for one cycle.
REQ-009 SHALL have port Busy, output, 1: a multiply/divide is in progress.
REQ-010 SHALL have port MDU_Result, output, 32: read data for MFHI/MFLO, feeding the E-stage result mux beside ALU_Result.

Function
REQ-011 SHALL use MDUOp encodings 0000 NOP, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MFHI, 0110 MFLO, 0111 MTHI, 1000 MTLO; other codes SHALL act as NOP.
REQ-012 SHALL implement a two-state FSM, IDLE and RUN; reset SHALL enter IDLE.
REQ-013 In IDLE, Start=1 with MULT/MULTU/DIV/DIVU SHALL latch the operation and operands, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-014 Busy SHALL be 1 exactly while in RUN: N cycles, starting the cycle after the Start edge.
REQ-015 The counter SHALL decrement each RUN cycle; at count 1, the edge SHALL write HI/LO, drop Busy and return to IDLE.
REQ-016 HI/LO SHALL hold old values throughout RUN and change only at that final edge.
REQ-017 MULT SHALL write the signed 64-bit product: HI = upper 32 bits, LO = lower 32 bits.
REQ-018 MULTU SHALL write the unsigned 64-bit product: HI = upper 32 bits, LO = lower 32 bits.
REQ-019 DIV SHALL write LO = signed quotient truncated toward zero and HI = remainder with the dividend's sign.
REQ-020 DIVU SHALL write LO = unsigned quotient and HI = unsigned remainder.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 Divide by zero (DIV/DIVU, Src_B=0) SHALL still run DIV_CYCLES and SHALL leave HI/LO unchanged.
REQ-023 MTHI/MTLO with Start=1 in IDLE SHALL write Src_A into HI/LO at that edge.
REQ-024 Start=1 in RUN, any op, SHALL be ignored; the upstream hazard unit stalls on Busy or Start.
REQ-025 A same-cycle Start with a mult/div op in IDLE SHALL not be affected by the HI/LO write path; only one op is accepted per edge.
REQ-026 MDU_Result SHALL be combinational: MDUOp=MFHI gives HI, MFLO gives LO, else 0, regardless of Start.
REQ-027 MDU_Result in RUN SHALL return the pre-operation HI/LO.

Reset
REQ-028 reset_n=0 SHALL immediately force HI=0, LO=0, Busy=0, counter=0, FSM=IDLE, and clear latched operands.
REQ-029 Reset asserted mid-RUN SHALL abort the operation; no HI/LO update SHALL occur after release.
REQ-030 The first Start SHALL be accepted on the first rising edge with reset_n=1.

Structure
REQ-031 MDUOp encodings and the IDLE/RUN state codes SHALL reside in the shared defines package alongside the ALUOp codes.
REQ-032 Arithmetic (signed/unsigned 64-bit product, quotient/remainder, overflow and zero-divisor cases) SHALL be one combinational sub-module mdu_calc, evaluated on latched operands.
REQ-033 mdu SHALL contain only the FSM, counter, operand latches and HI/LO registers.

Verification
REQ-034 MULT 0xFFFFFFFF x 0x00000002, Start 1 cycle -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-035 MULTU 0xFFFFFFFF x 0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-036 DIV 0xFFFFFFF9 (-7) / 2 -> Busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 MTHI 0x12345678, then DIVU 5/0 -> HI stays 0x12345678, LO stays 0 after 10 cycles; MFHI reads 0x12345678 throughout.
REQ-038 Start MULT, then MTLO 0xAAAA at busy cycle 2, then reset_n low at busy cycle 3 -> MTLO ignored, Busy=0, HI=LO=0 immediately; after release HI/LO stay 0 and a new Start is accepted.
